// File: rtl/brain_net_pkg.sv
// Shared types and default geometry for the data register bank and its sequencer.
package brain_net_pkg;

  localparam int NUM_REGS_DEF = 10;
  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2,
    SCAN   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/bank_read_mux.sv
// Combinational NUM_REGS:1 word select from the flattened bank outputs.
module bank_read_mux #(
  parameter int NUM_REGS = 10,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4
) (
  input  logic [NUM_REGS*DATA_W-1:0] bank_q_i,
  input  logic [ADDR_W-1:0]          sel_i,
  output logic [DATA_W-1:0]          word_o
);

  // AND-OR select; an out-of-range index yields zero
  always_comb begin
    word_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      word_o = word_o | ({DATA_W{sel_i == ADDR_W'(i)}} & bank_q_i[i*DATA_W +: DATA_W]);
    end
  end

endmodule

// File: rtl/data_bank_sequencer.sv
// Arbitrates host load, layer commit and readout scan onto the data register bank.
// Optional LOAD idle timeout with sticky timeout_err: define SEQ_TIMEOUT_EN.
module data_bank_sequencer
  import brain_net_pkg::*;
#(
  parameter int NUM_REGS    = NUM_REGS_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_req,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  output logic                       load_done,
  input  logic                       commit_req,
  output logic                       commit_ack,
  input  logic                       scan_req,
  input  logic [NUM_REGS*DATA_W-1:0] bank_q,
  output logic                       scan_valid,
  output logic [DATA_W-1:0]          scan_data,
  output logic [ADDR_W-1:0]          scan_index,
  input  logic                       scan_ready,
  output logic                       scan_done,
  output logic [ADDR_W-1:0]          bank_address,
  output logic [DATA_W-1:0]          bank_data_in,
  output logic                       bank_write_address,
  output logic                       bank_write_all,
  output logic                       busy
`ifdef SEQ_TIMEOUT_EN
  , output logic                     timeout_err
`endif
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  seq_state_t          state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                wr_all_q, wr_all_d;
  logic                ack_q, ack_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   mux_word_s;

`ifdef SEQ_TIMEOUT_EN
  localparam int IDLE_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(TIMEOUT_CYC - 1);
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                terr_q, terr_d;
`endif

  bank_read_mux #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W)
  ) u_read_mux (
    .bank_q_i (bank_q),
    .sel_i    (idx_q),
    .word_o   (mux_word_s)
  );

  // Next-state, index and bank control decode
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wr_addr_d = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    wr_all_d  = 1'b0;
    ack_d     = 1'b0;
    done_d    = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    idle_d    = idle_q;
    terr_d    = terr_q;
`endif
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (load_req) begin
          state_d = LOAD;
`ifdef SEQ_TIMEOUT_EN
          idle_d  = '0;
          terr_d  = 1'b0;
`endif
        end else if (commit_req) begin
          // Strobes are registered so they coincide with the COMMIT cycle
          state_d  = COMMIT;
          wr_all_d = 1'b1;
          ack_d    = 1'b1;
        end else if (scan_req) begin
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (in_valid) begin
          wr_addr_d = 1'b1;
          addr_d    = idx_q;
          data_d    = in_data;
`ifdef SEQ_TIMEOUT_EN
          idle_d    = '0;
`endif
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end else begin
`ifdef SEQ_TIMEOUT_EN
          if (idle_q == IDLE_LIM) begin
            state_d = IDLE;
            idx_d   = '0;
            idle_d  = '0;
            terr_d  = 1'b1;
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
`else
          state_d = LOAD;
`endif
        end
      end
      COMMIT: begin
        state_d = IDLE;
      end
      SCAN: begin
        if (scan_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State and registered bank-control outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      wr_addr_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_all_q  <= 1'b0;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      idle_q    <= '0;
      terr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wr_addr_q <= wr_addr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_all_q  <= wr_all_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
`ifdef SEQ_TIMEOUT_EN
      idle_q    <= idle_d;
      terr_q    <= terr_d;
`endif
    end
  end

  assign in_ready           = (state_q == LOAD);
  assign busy               = (state_q != IDLE);
  assign scan_valid         = (state_q == SCAN);
  assign scan_index         = scan_valid ? idx_q : '0;
  assign scan_data          = scan_valid ? mux_word_s : '0;
  assign scan_done          = scan_valid & scan_ready & (idx_q == LAST_IDX);
  assign bank_write_address = wr_addr_q;
  assign bank_address       = addr_q;
  assign bank_data_in       = data_q;
  assign bank_write_all     = wr_all_q;
  assign commit_ack         = ack_q;
  assign load_done          = done_q;
`ifdef SEQ_TIMEOUT_EN
  assign timeout_err        = terr_q;
`endif

endmodule

// File: tb/tb_data_bank_sequencer.sv
// Directed table-driven bench for data_bank_sequencer plus reset and timeout sequences.
module tb_data_bank_sequencer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load_req = 1'b0, in_valid = 1'b0, commit_req = 1'b0, scan_req = 1'b0, scan_ready = 1'b0;
  logic [31:0]  in_data = 32'd0;
  logic [319:0] bank_q;
  logic         in_ready, load_done, commit_ack, scan_valid, scan_done;
  logic         bank_write_address, bank_write_all, busy;
  logic [31:0]  scan_data, bank_data_in;
  logic [3:0]   scan_index, bank_address;
`ifdef SEQ_TIMEOUT_EN
  logic         timeout_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_bank_sequencer #(.NUM_REGS(10), .DATA_W(32), .ADDR_W(4), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .load_done(load_done), .commit_req(commit_req), .commit_ack(commit_ack),
    .scan_req(scan_req), .bank_q(bank_q), .scan_valid(scan_valid), .scan_data(scan_data),
    .scan_index(scan_index), .scan_ready(scan_ready), .scan_done(scan_done),
    .bank_address(bank_address), .bank_data_in(bank_data_in),
    .bank_write_address(bank_write_address), .bank_write_all(bank_write_all), .busy(busy)
`ifdef SEQ_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  typedef struct {
    logic lr, iv, cr, sr, rdy;
    logic [31:0] d;
    logic ir, wa, dn, wall, ack, bsy, sv, sdn;
    logic [3:0] a, si;
    logic [31:0] wd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int lr, int iv, int d, int cr, int sr, int rdy,
                              int ir, int wa, int a, int wd,
                              int dn, int wall, int ack, int bsy,
                              int sv, int si, int sdn);
    vec_t v;
    v.lr = (lr != 0); v.iv = (iv != 0); v.d = 32'(d); v.cr = (cr != 0);
    v.sr = (sr != 0); v.rdy = (rdy != 0);
    v.ir = (ir != 0); v.wa = (wa != 0); v.a = 4'(a); v.wd = 32'(wd);
    v.dn = (dn != 0); v.wall = (wall != 0); v.ack = (ack != 0); v.bsy = (bsy != 0);
    v.sv = (sv != 0); v.si = 4'(si); v.sdn = (sdn != 0);
    return v;
  endfunction

  // Address/data fields are only meaningful while their qualifier is high
  function automatic logic [79:0] pk(logic ir, logic wa, logic [3:0] a, logic [31:0] wd,
                                     logic dn, logic wall, logic ack, logic bsy,
                                     logic sv, logic [3:0] si, logic [31:0] sd, logic sdn);
    return {ir, wa, wa ? a : 4'd0, wa ? wd : 32'd0, dn, wall, ack, bsy,
            sv, sv ? si : 4'd0, sv ? sd : 32'd0, sdn};
  endfunction

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [79:0] observed();
    return pk(in_ready, bank_write_address, bank_address, bank_data_in, load_done,
              bank_write_all, commit_ack, busy, scan_valid, scan_index, scan_data, scan_done);
  endfunction

  initial begin
    int w;
    int pw, pa, pd;
    logic gap;
    vec_t v;
    logic [79:0] exp_s;

    for (int i = 0; i < 10; i++) bank_q[i*32 +: 32] = 32'hA0 + 32'(i);

    // reset state, then LOAD with gaps before words 3 and 7
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0));
    tbl.push_back(mk(1,0,0, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0));
    w = 0; pw = 0; pa = 0; pd = 0;
    for (int s = 0; s < 12; s++) begin
      gap = (s == 3) || (s == 8);
      tbl.push_back(mk(1, gap ? 0 : 1, gap ? 0 : 'h100 + w, 0,0,0, 1, pw, pa, pd, 0,0,0,1, 0,0,0));
      if (!gap) begin pw = 1; pa = w; pd = 'h100 + w; w++; end
      else pw = 0;
    end
    tbl.push_back(mk(0,0,0, 0,0,0, 0,1,9,'h109, 1,0,0,0, 0,0,0));
    // commit
    tbl.push_back(mk(0,0,0, 1,0,0, 0,0,0,0, 0,0,0,0, 0,0,0));
    tbl.push_back(mk(0,0,0, 1,0,0, 0,0,0,0, 0,1,1,1, 0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0));
    // all three requests together: LOAD, then COMMIT, then SCAN
    tbl.push_back(mk(1,0,0, 1,1,0, 0,0,0,0, 0,0,0,0, 0,0,0));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(1,1,'h200 + i, 1,1,0, 1, (i > 0) ? 1 : 0, i - 1, 'h200 + i - 1, 0,0,0,1, 0,0,0));
    tbl.push_back(mk(0,0,0, 1,1,0, 0,1,9,'h209, 1,0,0,0, 0,0,0));
    tbl.push_back(mk(0,0,0, 1,1,0, 0,0,0,0, 0,1,1,1, 0,0,0));
    tbl.push_back(mk(0,0,0, 0,1,0, 0,0,0,0, 0,0,0,0, 0,0,0));
    for (int j = 0; j < 10; j++) begin
      tbl.push_back(mk(0,0,0, 0,1,0, 0,0,0,0, 0,0,0,1, 1,j,0));
      tbl.push_back(mk(0,0,0, 0,1,1, 0,0,0,0, 0,0,0,1, 1,j,(j == 9) ? 1 : 0));
    end
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0));

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      v = tbl[k];
      @(negedge clk);
      load_req = v.lr; in_valid = v.iv; in_data = v.d;
      commit_req = v.cr; scan_req = v.sr; scan_ready = v.rdy;
      #1;
      exp_s = pk(v.ir, v.wa, v.a, v.wd, v.dn, v.wall, v.ack, v.bsy,
                 v.sv, v.si, 32'hA0 + 32'(v.si), v.sdn);
      chk($sformatf("vec%0d", k), observed(), exp_s);
    end

    // reset in the middle of a load, then a fresh load restarts at address 0
    @(negedge clk); load_req = 1'b1; in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); in_valid = 1'b1; in_data = 32'h300 + 32'(k);
    end
    @(negedge clk); in_valid = 1'b0; #1;
    chk("pre_rst_write", {43'd0, bank_write_address, bank_address, bank_data_in},
        {43'd0, 1'b1, 4'd3, 32'h303});
    #2 rst_n = 1'b0; #1;
    chk("rst_async_zero", {in_ready, load_done, commit_ack, scan_valid, scan_data, scan_index,
        scan_done, bank_address, bank_data_in, bank_write_address, bank_write_all, busy}, 80'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); in_valid = 1'b1; in_data = 32'h310;
    @(negedge clk); in_valid = 1'b0; #1;
    chk("reload_addr0", {43'd0, bank_write_address, bank_address, bank_data_in},
        {43'd0, 1'b1, 4'd0, 32'h310});
    @(negedge clk); load_req = 1'b0; rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;

`ifdef SEQ_TIMEOUT_EN
    #1 chk("terr_reset", {79'd0, timeout_err}, 80'd0);
    @(negedge clk); load_req = 1'b1; in_valid = 1'b0;
    @(negedge clk); in_valid = 1'b1; in_data = 32'h400;
    @(negedge clk); in_data = 32'h401;
    @(negedge clk); in_valid = 1'b0;
    repeat (7) @(negedge clk);
    #1 chk("to_not_yet", {78'd0, busy, timeout_err}, {78'd0, 1'b1, 1'b0});
    @(negedge clk); #1;
    chk("to_abort", {77'd0, busy, timeout_err, load_done}, {77'd0, 1'b0, 1'b1, 1'b0});
    @(negedge clk); #1;
    chk("to_clear_on_load", {78'd0, busy, timeout_err}, {78'd0, 1'b1, 1'b0});
    load_req = 1'b0; rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_bank_sequencer.md
Name: data_bank_sequencer

Overview:
- Controller in front of the 10-entry data register bank.
- Arbitrates three level-held requesters and drives the bank's control pins (address, dataIn, writeAddress, writeAll):
  - a host loader, which streams words in one per address;
  - a layer-commit source, which drives writeAll;
  - a readout scanner, which streams bank contents out over valid/ready.
- Sits between the host/training interface, the neuron-layer datapath and the bank.

Parameters:
- NUM_REGS, 10, bank entries; legal range 2..16.
- DATA_W, 32, word width.
- ADDR_W, 4, bank address width; 2**ADDR_W >= NUM_REGS.
- TIMEOUT_CYC, 255, LOAD idle-cycle limit; used only with SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_req  in  1  host requests a full sequential load; held until load_done.
- in_valid  in  1  host word valid.
- in_data  in  DATA_W  host word.
- in_ready  out  1  sequencer accepts in_data this cycle.
- load_done  out  1  1-cycle pulse after word NUM_REGS-1 is written.
- commit_req  in  1  layer requests writeAll; held until commit_ack.
- commit_ack  out  1  1-cycle pulse, same cycle writeAll is asserted.
- scan_req  in  1  request readout of all entries; held until scan_done.
- bank_q  in  NUM_REGS*DATA_W  bank outputs, entry i at bits [i*DATA_W +: DATA_W].
- scan_valid  out  1  scan word valid.
- scan_data  out  DATA_W  scan word.
- scan_index  out  ADDR_W  entry index of scan_data.
- scan_ready  in  1  consumer accepts the scan word.
- scan_done  out  1  1-cycle pulse with the final scan handshake.
- bank_address  out  ADDR_W  bank address.
- bank_data_in  out  DATA_W  bank dataIn.
- bank_write_address  out  1  bank writeAddress.
- bank_write_all  out  1  bank writeAll.
- busy  out  1  state != IDLE.
- timeout_err  out  1  sticky error flag; present only with SEQ_TIMEOUT_EN.

Behaviour:
- Reset: every output is 0; state = IDLE; index counter = 0.
- States: IDLE, LOAD, COMMIT, SCAN.
- IDLE arbitration, fixed priority: load_req > commit_req > scan_req.
  - Losing requests are held off; they are not dropped.
  - Requests that arrive while busy wait until the return to IDLE.
- LOAD:
  - in_ready = 1, combinational in state.
  - On in_valid & in_ready: bank_write_address = 1, bank_address = idx, bank_data_in = in_data, registered. The bank captures the word at the next edge, so the word is written one cycle after acceptance.
  - idx increments per accepted word.
  - Accept at idx = NUM_REGS-1: load_done pulses on the following cycle, together with the last write; then go to IDLE with idx = 0.
  - Gaps in in_valid stall without writing.
  - in_ready is 0 in all states other than LOAD.
- COMMIT:
  - Exactly one cycle with bank_write_all = 1 and commit_ack = 1; then IDLE.
  - bank_write_address is never 1 in the same cycle as bank_write_all.
- SCAN:
  - scan_data = bank_q slice[idx]; scan_index = idx; scan_valid = 1.
  - Advance idx on scan_ready.
  - The handshake at idx = NUM_REGS-1 asserts scan_done in that same cycle; then IDLE.
  - scan_data must stay stable while scan_valid & !scan_ready.
- No two of these states overlap, so the bank is never written during a scan.
- Minimum gap between operations: one IDLE cycle.
- Back-to-back: a load_req still held after load_done starts a new LOAD; the requester deasserts on done.
- Reset mid-operation: return to IDLE at once, with outputs 0.
  - A partially loaded bank is left as-is; this block has no bank-clear.
- bank_address is never driven >= NUM_REGS.

Optional Feature:
- Macro: SEQ_TIMEOUT_EN.
- Defined:
  - In LOAD, an idle counter counts consecutive cycles without in_valid and resets on each accept.
  - On reaching TIMEOUT_CYC: abort to IDLE, set idx = 0, set timeout_err, and do not pulse load_done.
  - timeout_err is sticky and clears only on rst_n or on the next LOAD entry.
- Undefined: LOAD waits indefinitely; the timeout_err port does not exist.

Decomposition:
- Shared package brain_net_pkg:
  - state enum seq_state_t (IDLE, LOAD, COMMIT, SCAN);
  - constants NUM_REGS_DEF = 10, DATA_W_DEF = 32, ADDR_W_DEF = 4.
- One natural sub-module, bank_read_mux: combinational NUM_REGS:1 word select for the scan path.
- FSM, counters and the write path stay in the top module.

Test Plan:
- Load: reset, hold load_req, stream words 0x100+i for i = 0..9 with in_valid gaps at i = 3 and 7 -> ten writes to addr 0..9 in order, load_done once, no writes during the gaps.
- Commit: after the load, hold commit_req -> exactly one cycle of bank_write_all = 1 with commit_ack; bank_write_address = 0 throughout; return to IDLE.
- Arbitration: raise load_req, commit_req and scan_req in the same cycle -> LOAD first, then COMMIT, then SCAN; none are lost.
- Scan with backpressure: bank_q entry i = 0xA0+i, scan_ready toggled 1/0 -> scan_data 0xA0..0xA9 in order, stable while stalled, scan_done on the handshake at index 9.
- Reset mid-LOAD: assert rst_n = 0 after 4 words -> all outputs 0 asynchronously; a new load then starts at address 0.
- Timeout (SEQ_TIMEOUT_EN defined, TIMEOUT_CYC = 8): enter LOAD, 2 words, then 8 idle cycles -> timeout_err = 1, IDLE, no load_done; the next LOAD clears timeout_err.
